// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset release sequencer: FSM state encoding,
// stage-index width and the counter-width helper.
package reset_seq_pkg;

  // Width of the stage index and of the FAIL_STAGE output (up to 16 stages).
  localparam int STAGE_IDX_W = 4;

  typedef enum logic [2:0] {
    ST_WAIT_FAB = 3'd0,
    ST_HOLD     = 3'd1,
    ST_WAIT_RDY = 3'd2,
    ST_DONE     = 3'd3,
    ST_ERROR    = 3'd4
  } seq_state_e;

  // Bits needed for a counter that must be able to hold max(a, b).
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    if (m < 1) begin
      return 1;
    end else begin
      return $clog2(m + 1);
    end
  endfunction

endpackage

// File: rtl/reset_sync_2ff.sv
// Two-flop synchronizer for an asynchronous active-high-release reset level.
// The synchronized output is forced low while rst_i is asserted, so a
// release is never reported until two clean edges have passed.
module reset_sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage metastability filter on the asynchronous input.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/reset_release_sequencer.sv
// Ordered, handshaked release of per-subsystem resets. After the fabric
// release is seen, each stage is held for HOLD_CYCLES, released, and must
// raise its ready before the next stage starts. A stalled stage or a ready
// drop after completion parks the block in ERROR until a restart.
module reset_release_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES     = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   FABRIC_RESET_N,
  input  logic                   SOFT_RST_REQ,
  input  logic [NUM_STAGES-1:0]  STAGE_READY,
  output logic [NUM_STAGES-1:0]  STAGE_RESET_N,
  output logic                   ALL_READY,
  output logic                   BUSY,
  output logic                   TIMEOUT_ERR,
  output logic [STAGE_IDX_W-1:0] FAIL_STAGE
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [STAGE_IDX_W-1:0] LAST_IDX = STAGE_IDX_W'(NUM_STAGES - 1);

  logic fab_ok;

  seq_state_e             state_q, state_d;
  logic [STAGE_IDX_W-1:0] stage_q, stage_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [STAGE_IDX_W-1:0] fail_q, fail_d;
  logic [NUM_STAGES-1:0]  ready_q;
  logic [NUM_STAGES-1:0]  rst_n_q, rst_n_d;
  logic                   all_ready_q, busy_q, err_q;

  logic                   cur_ready;
  logic [NUM_STAGES-1:0]  fall;
  logic [STAGE_IDX_W-1:0] low_fall_idx;
  logic [CNT_W-1:0]       cnt_inc;

  reset_sync_2ff u_fab_sync (
    .clk_i   (CLK),
    .rst_i   (RST),
    .async_i (FABRIC_RESET_N),
    .sync_o  (fab_ok)
  );

  assign fall    = ready_q & ~STAGE_READY;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // Select the ready of the active stage and find the lowest falling ready.
  always_comb begin
    cur_ready    = 1'b0;
    low_fall_idx = {STAGE_IDX_W{1'b0}};
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (stage_q == STAGE_IDX_W'(i)) begin
        cur_ready = STAGE_READY[i];
      end else begin
        cur_ready = cur_ready;
      end
    end
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (fall[i]) begin
        low_fall_idx = STAGE_IDX_W'(i);
      end else begin
        low_fall_idx = low_fall_idx;
      end
    end
  end

  // Sequencer next-state logic; restart events override every state.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    if (!fab_ok) begin
      state_d = ST_WAIT_FAB;
      stage_d = {STAGE_IDX_W{1'b0}};
      cnt_d   = {CNT_W{1'b0}};
      fail_d  = {STAGE_IDX_W{1'b0}};
    end else if (SOFT_RST_REQ) begin
      state_d = ST_HOLD;
      stage_d = {STAGE_IDX_W{1'b0}};
      cnt_d   = {CNT_W{1'b0}};
      fail_d  = {STAGE_IDX_W{1'b0}};
    end else begin
      case (state_q)
        ST_WAIT_FAB: begin
          state_d = ST_HOLD;
          stage_d = {STAGE_IDX_W{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
        end
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_WAIT_RDY;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_WAIT_RDY: begin
          // Ready is checked first so it wins over a simultaneous expiry.
          if (cur_ready) begin
            cnt_d = {CNT_W{1'b0}};
            if (stage_q == LAST_IDX) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_HOLD;
              stage_d = stage_q + STAGE_IDX_W'(1);
            end
          end else if (TO_EN && (cnt_q == TO_LAST)) begin
            state_d = ST_ERROR;
            fail_d  = stage_q;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_DONE: begin
          if (|fall) begin
            state_d = ST_ERROR;
            fail_d  = low_fall_idx;
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_ERROR: begin
          state_d = ST_ERROR;
        end
        default: begin
          state_d = ST_WAIT_FAB;
          stage_d = {STAGE_IDX_W{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          fail_d  = {STAGE_IDX_W{1'b0}};
        end
      endcase
    end
  end

  // Release mask follows the next state: earlier stages stay released.
  always_comb begin
    rst_n_d = {NUM_STAGES{1'b0}};
    for (int i = 0; i < NUM_STAGES; i++) begin
      case (state_d)
        ST_DONE:     rst_n_d[i] = 1'b1;
        ST_HOLD:     rst_n_d[i] = (STAGE_IDX_W'(i) <  stage_d);
        ST_WAIT_RDY: rst_n_d[i] = (STAGE_IDX_W'(i) <= stage_d);
        default:     rst_n_d[i] = 1'b0;
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_WAIT_FAB;
      stage_q     <= {STAGE_IDX_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      fail_q      <= {STAGE_IDX_W{1'b0}};
      ready_q     <= {NUM_STAGES{1'b0}};
      rst_n_q     <= {NUM_STAGES{1'b0}};
      all_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      cnt_q       <= cnt_d;
      fail_q      <= fail_d;
      ready_q     <= STAGE_READY;
      rst_n_q     <= rst_n_d;
      all_ready_q <= (state_d == ST_DONE);
      busy_q      <= (state_d == ST_WAIT_FAB) || (state_d == ST_HOLD) ||
                     (state_d == ST_WAIT_RDY);
      err_q       <= (state_d == ST_ERROR);
    end
  end

  assign STAGE_RESET_N = rst_n_q;
  assign ALL_READY     = all_ready_q;
  assign BUSY          = busy_q;
  assign TIMEOUT_ERR   = err_q;
  assign FAIL_STAGE    = fail_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Directed bench for reset_release_sequencer with 3 stages, hold 4, timeout 16.
module tb_reset_release_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       FAB;
  logic       SOFT;
  logic [2:0] READY;
  logic [2:0] SRN;
  logic       ALL_RDY;
  logic       BUSY_O;
  logic       TERR;
  logic [3:0] FS;

  int n_checks = 0;
  int n_fail   = 0;

  reset_release_sequencer #(
    .NUM_STAGES     (3),
    .HOLD_CYCLES    (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .FABRIC_RESET_N (FAB),
    .SOFT_RST_REQ   (SOFT),
    .STAGE_READY    (READY),
    .STAGE_RESET_N  (SRN),
    .ALL_READY      (ALL_RDY),
    .BUSY           (BUSY_O),
    .TIMEOUT_ERR    (TERR),
    .FAIL_STAGE     (FS)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Hard reset, then release with the fabric still low.
  task automatic start_clean(input logic [2:0] rdy);
    RST = 1'b1; FAB = 1'b0; SOFT = 1'b0; READY = rdy;
    tick(2);
    RST = 1'b0;
  endtask

  // Nominal release timeline; the next edge is edge 0 with FAB already high.
  task automatic release_and_check(input string tag);
    tick(6);
    n_checks++; if (SRN !== 3'b000) begin n_fail++; $display("FAIL %s_e5_srn: got %b want %b", tag, SRN, 3'b000); end
    n_checks++; if (BUSY_O !== 1'b1) begin n_fail++; $display("FAIL %s_e5_busy: got %b want %b", tag, BUSY_O, 1'b1); end
    tick(1);
    n_checks++; if (SRN !== 3'b001) begin n_fail++; $display("FAIL %s_e6_srn: got %b want %b", tag, SRN, 3'b001); end
    tick(4);
    n_checks++; if (SRN !== 3'b001) begin n_fail++; $display("FAIL %s_e10_srn: got %b want %b", tag, SRN, 3'b001); end
    tick(1);
    n_checks++; if (SRN !== 3'b011) begin n_fail++; $display("FAIL %s_e11_srn: got %b want %b", tag, SRN, 3'b011); end
    tick(4);
    n_checks++; if (SRN !== 3'b011) begin n_fail++; $display("FAIL %s_e15_srn: got %b want %b", tag, SRN, 3'b011); end
    tick(1);
    n_checks++; if (SRN !== 3'b111) begin n_fail++; $display("FAIL %s_e16_srn: got %b want %b", tag, SRN, 3'b111); end
    n_checks++; if (ALL_RDY !== 1'b0) begin n_fail++; $display("FAIL %s_e16_all: got %b want %b", tag, ALL_RDY, 1'b0); end
    tick(1);
    n_checks++; if (ALL_RDY !== 1'b1) begin n_fail++; $display("FAIL %s_e17_all: got %b want %b", tag, ALL_RDY, 1'b1); end
    n_checks++; if (BUSY_O !== 1'b0) begin n_fail++; $display("FAIL %s_e17_busy: got %b want %b", tag, BUSY_O, 1'b0); end
    n_checks++; if (SRN !== 3'b111) begin n_fail++; $display("FAIL %s_e17_srn: got %b want %b", tag, SRN, 3'b111); end
  endtask

  task automatic test_reset();
    RST = 1'b1; FAB = 1'b1; SOFT = 1'b0; READY = 3'b111;
    tick(3);
    n_checks++; if (SRN !== 3'b000) begin n_fail++; $display("FAIL rst_srn: got %b want %b", SRN, 3'b000); end
    n_checks++; if (ALL_RDY !== 1'b0) begin n_fail++; $display("FAIL rst_all: got %b want %b", ALL_RDY, 1'b0); end
    n_checks++; if (BUSY_O !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b want %b", BUSY_O, 1'b1); end
    n_checks++; if (TERR !== 1'b0) begin n_fail++; $display("FAIL rst_terr: got %b want %b", TERR, 1'b0); end
    n_checks++; if (FS !== 4'd0) begin n_fail++; $display("FAIL rst_fs: got %0d want %0d", FS, 4'd0); end
  endtask

  task automatic test_nominal();
    start_clean(3'b111);
    FAB = 1'b1;
    release_and_check("nom");
  endtask

  task automatic test_timeout();
    start_clean(3'b101);
    FAB = 1'b1;
    tick(27);
    n_checks++; if (SRN !== 3'b011) begin n_fail++; $display("FAIL to_e26_srn: got %b want %b", SRN, 3'b011); end
    n_checks++; if (TERR !== 1'b0) begin n_fail++; $display("FAIL to_e26_terr: got %b want %b", TERR, 1'b0); end
    tick(1);
    n_checks++; if (SRN !== 3'b000) begin n_fail++; $display("FAIL to_e27_srn: got %b want %b", SRN, 3'b000); end
    n_checks++; if (TERR !== 1'b1) begin n_fail++; $display("FAIL to_e27_terr: got %b want %b", TERR, 1'b1); end
    n_checks++; if (FS !== 4'd1) begin n_fail++; $display("FAIL to_e27_fs: got %0d want %0d", FS, 4'd1); end
    n_checks++; if (BUSY_O !== 1'b0) begin n_fail++; $display("FAIL to_e27_busy: got %b want %b", BUSY_O, 1'b0); end
    tick(3);
    n_checks++; if (TERR !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want %b", TERR, 1'b1); end
  endtask

  task automatic test_soft_restart();
    start_clean(3'b101);
    FAB = 1'b1;
    tick(14);
    SOFT = 1'b1;
    tick(1);
    SOFT = 1'b0;
    n_checks++; if (SRN !== 3'b000) begin n_fail++; $display("FAIL sr1_srn: got %b want %b", SRN, 3'b000); end
    n_checks++; if (BUSY_O !== 1'b1) begin n_fail++; $display("FAIL sr1_busy: got %b want %b", BUSY_O, 1'b1); end
    tick(3);
    n_checks++; if (SRN !== 3'b000) begin n_fail++; $display("FAIL sr1_pre_srn: got %b want %b", SRN, 3'b000); end
    tick(1);
    n_checks++; if (SRN !== 3'b001) begin n_fail++; $display("FAIL sr1_rel_srn: got %b want %b", SRN, 3'b001); end
    tick(5);
    n_checks++; if (SRN !== 3'b011) begin n_fail++; $display("FAIL sr1_s1_srn: got %b want %b", SRN, 3'b011); end
    tick(15);
    n_checks++; if (TERR !== 1'b0) begin n_fail++; $display("FAIL sr_pre_to: got %b want %b", TERR, 1'b0); end
    tick(1);
    n_checks++; if (TERR !== 1'b1) begin n_fail++; $display("FAIL sr_to_terr: got %b want %b", TERR, 1'b1); end
    n_checks++; if (FS !== 4'd1) begin n_fail++; $display("FAIL sr_to_fs: got %0d want %0d", FS, 4'd1); end
    SOFT = 1'b1;
    tick(1);
    SOFT = 1'b0;
    n_checks++; if (TERR !== 1'b0) begin n_fail++; $display("FAIL sr2_terr: got %b want %b", TERR, 1'b0); end
    n_checks++; if (FS !== 4'd0) begin n_fail++; $display("FAIL sr2_fs: got %0d want %0d", FS, 4'd0); end
    n_checks++; if (BUSY_O !== 1'b1) begin n_fail++; $display("FAIL sr2_busy: got %b want %b", BUSY_O, 1'b1); end
    tick(3);
    n_checks++; if (SRN !== 3'b000) begin n_fail++; $display("FAIL sr2_pre_srn: got %b want %b", SRN, 3'b000); end
    tick(1);
    n_checks++; if (SRN !== 3'b001) begin n_fail++; $display("FAIL sr2_rel_srn: got %b want %b", SRN, 3'b001); end
  endtask

  task automatic test_ready_drop();
    start_clean(3'b111);
    FAB = 1'b1;
    release_and_check("drop");
    READY = 3'b011;
    tick(1);
    READY = 3'b111;
    n_checks++; if (TERR !== 1'b1) begin n_fail++; $display("FAIL drop_terr: got %b want %b", TERR, 1'b1); end
    n_checks++; if (FS !== 4'd2) begin n_fail++; $display("FAIL drop_fs: got %0d want %0d", FS, 4'd2); end
    n_checks++; if (ALL_RDY !== 1'b0) begin n_fail++; $display("FAIL drop_all: got %b want %b", ALL_RDY, 1'b0); end
    n_checks++; if (SRN !== 3'b000) begin n_fail++; $display("FAIL drop_srn: got %b want %b", SRN, 3'b000); end
    SOFT = 1'b1;
    tick(1);
    SOFT = 1'b0;
    tick(15);
    n_checks++; if (ALL_RDY !== 1'b1) begin n_fail++; $display("FAIL drop2_all: got %b want %b", ALL_RDY, 1'b1); end
    READY = 3'b001;
    tick(1);
    READY = 3'b111;
    n_checks++; if (FS !== 4'd1) begin n_fail++; $display("FAIL drop2_fs_lowest: got %0d want %0d", FS, 4'd1); end
    n_checks++; if (TERR !== 1'b1) begin n_fail++; $display("FAIL drop2_terr: got %b want %b", TERR, 1'b1); end
  endtask

  task automatic test_fabric_drop();
    start_clean(3'b111);
    FAB = 1'b1;
    release_and_check("fab");
    FAB = 1'b0;
    tick(2);
    n_checks++; if (SRN !== 3'b111) begin n_fail++; $display("FAIL fab_e2_srn: got %b want %b", SRN, 3'b111); end
    n_checks++; if (ALL_RDY !== 1'b1) begin n_fail++; $display("FAIL fab_e2_all: got %b want %b", ALL_RDY, 1'b1); end
    tick(1);
    n_checks++; if (SRN !== 3'b000) begin n_fail++; $display("FAIL fab_e3_srn: got %b want %b", SRN, 3'b000); end
    n_checks++; if (BUSY_O !== 1'b1) begin n_fail++; $display("FAIL fab_e3_busy: got %b want %b", BUSY_O, 1'b1); end
    n_checks++; if (ALL_RDY !== 1'b0) begin n_fail++; $display("FAIL fab_e3_all: got %b want %b", ALL_RDY, 1'b0); end
    FAB = 1'b1;
    release_and_check("fab_re");
  endtask

  task automatic test_async_rst();
    start_clean(3'b111);
    FAB = 1'b1;
    tick(14);
    n_checks++; if (SRN !== 3'b011) begin n_fail++; $display("FAIL arst_pre_srn: got %b want %b", SRN, 3'b011); end
    #2;
    RST = 1'b1;
    #1;
    n_checks++; if (SRN !== 3'b000) begin n_fail++; $display("FAIL arst_srn: got %b want %b", SRN, 3'b000); end
    n_checks++; if (BUSY_O !== 1'b1) begin n_fail++; $display("FAIL arst_busy: got %b want %b", BUSY_O, 1'b1); end
    n_checks++; if (ALL_RDY !== 1'b0) begin n_fail++; $display("FAIL arst_all: got %b want %b", ALL_RDY, 1'b0); end
    #2;
    RST = 1'b0;
    release_and_check("arst");
  endtask

  task automatic test_ready_timeout_tie();
    start_clean(3'b101);
    FAB = 1'b1;
    tick(27);
    READY = 3'b111;
    tick(1);
    n_checks++; if (TERR !== 1'b0) begin n_fail++; $display("FAIL tie_terr: got %b want %b", TERR, 1'b0); end
    n_checks++; if (BUSY_O !== 1'b1) begin n_fail++; $display("FAIL tie_busy: got %b want %b", BUSY_O, 1'b1); end
    tick(4);
    n_checks++; if (SRN !== 3'b111) begin n_fail++; $display("FAIL tie_s2_srn: got %b want %b", SRN, 3'b111); end
    tick(1);
    n_checks++; if (ALL_RDY !== 1'b1) begin n_fail++; $display("FAIL tie_all: got %b want %b", ALL_RDY, 1'b1); end
  endtask

  initial begin
    RST = 1'b1; FAB = 1'b0; SOFT = 1'b0; READY = 3'b000;
    test_reset();
    test_nominal();
    test_timeout();
    test_soft_restart();
    test_ready_drop();
    test_fabric_drop();
    test_async_rst();
    test_ready_timeout_tie();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
